// File: rtl/bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with optional two's-complement input, overflow flag and significant-digit count.
module bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5,
   parameter int SIGNED = 0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [WIDTH-1:0]                   din,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [4*DIGITS-1:0]                dout,
   output logic                               neg,
   output logic                               ovf,
   output logic [$clog2(DIGITS+1)-1:0]        nsig,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [1:0]                         dbg_state
);

   localparam int NW = $clog2(DIGITS+1);
   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, and out_valid holds until taken.

   state_t              r_state;
   logic [WIDTH-1:0]    r_bin;
   logic [4*DIGITS-1:0] r_bcd;
   logic [CW-1:0]       r_cnt;
   logic                r_ovf_s;
   logic                r_neg_s;
   logic [4*DIGITS-1:0] r_dout;
   logic                r_neg;
   logic                r_ovf;
   logic [NW-1:0]       r_nsig;

   logic                w_is_neg;
   logic [WIDTH-1:0]    w_mag;
   logic [4*DIGITS-1:0] w_adj;
   logic [4*DIGITS-1:0] w_bcd_nxt;
   logic                w_carry;
   logic                w_last;
   logic [NW-1:0]       w_nsig;

   assign w_is_neg = (SIGNED != 0) && din[WIDTH-1];
   assign w_mag    = w_is_neg ? (~din + WIDTH'(1)) : din;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_add3
         assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? (r_bcd[4*g +: 4] + 4'd3)
                                                             : r_bcd[4*g +: 4];
      end
   endgenerate

   // The bit leaving the top digit means the value no longer fits; it is dropped (mod 10^DIGITS).
   assign w_carry   = w_adj[4*DIGITS-1];
   assign w_bcd_nxt = {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
   assign w_last    = (r_cnt == CW'(WIDTH-1));

   always_comb begin
      w_nsig = NW'(1);
      for (int i = 1; i < DIGITS; i++) begin
         if (w_bcd_nxt[4*i +: 4] != 4'd0) w_nsig = NW'(i+1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_ovf_s <= 1'b0;
         r_neg_s <= 1'b0;
         r_dout  <= '0;
         r_neg   <= 1'b0;
         r_ovf   <= 1'b0;
         r_nsig  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_bin   <= w_mag;
                  r_neg_s <= w_is_neg;
                  r_bcd   <= '0;
                  r_ovf_s <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_bcd   <= w_bcd_nxt;
               r_bin   <= {r_bin[WIDTH-2:0], 1'b0};
               r_ovf_s <= r_ovf_s | w_carry;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_dout  <= w_bcd_nxt;
                  r_neg   <= r_neg_s;
                  r_ovf   <= r_ovf_s | w_carry;
                  r_nsig  <= w_nsig;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign dout      = r_dout;
   assign neg       = r_neg;
   assign ovf       = r_ovf;
   assign nsig      = r_nsig;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_seq.sv
// Bench for bcd_seq: three instances (default, DIGITS=4, SIGNED=1) share one stimulus
// stream and are checked every cycle against a decimal-arithmetic model.
module tb_bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] din = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;

   logic        ir[3], ov[3], dng[3], dof[3];
   logic [2:0]  dns[3];
   logic [1:0]  dbg[3];
   logic [19:0] dout0, dout2;
   logic [15:0] dout1;
   logic [19:0] dd[3];

   int checks = 0;
   int failures = 0;

   assign dd[0] = dout0;
   assign dd[1] = {4'h0, dout1};
   assign dd[2] = dout2;

   always #5 clk = ~clk;

   bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_def (
      .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(ir[0]),
      .dout(dout0), .neg(dng[0]), .ovf(dof[0]), .nsig(dns[0]), .out_valid(ov[0]),
      .out_ready(out_ready), .dbg_state(dbg[0]));

   bcd_seq #(.WIDTH(16), .DIGITS(4), .SIGNED(0)) u_d4 (
      .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(ir[1]),
      .dout(dout1), .neg(dng[1]), .ovf(dof[1]), .nsig(dns[1]), .out_valid(ov[1]),
      .out_ready(out_ready), .dbg_state(dbg[1]));

   bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) u_sgn (
      .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(ir[2]),
      .dout(dout2), .neg(dng[2]), .ovf(dof[2]), .nsig(dns[2]), .out_valid(ov[2]),
      .out_ready(out_ready), .dbg_state(dbg[2]));

   // ---------------- reference model ----------------
   function automatic int dg(input int k);
      return (k == 1) ? 4 : 5;
   endfunction

   function automatic bit sg(input int k);
      return (k == 2);
   endfunction

   function automatic logic [19:0] to_bcd(input int unsigned v);
      logic [19:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [2:0] nsig_of(input int unsigned v);
      int unsigned x;
      int n, i;
      x = v; n = 1; i = 0;
      while (x != 0) begin
         i++;
         if (x % 10 != 0) n = i;
         x = x / 10;
      end
      return 3'(n);
   endfunction

   int          m_wait = 0;
   bit          m_done = 1'b0;
   logic [19:0] m_dout[3] = '{default: '0};
   logic        m_neg[3]  = '{default: 1'b0};
   logic        m_ovf[3]  = '{default: 1'b0};
   logic [2:0]  m_nsig[3] = '{default: '0};
   logic [19:0] p_dout[3];
   logic        p_neg[3], p_ovf[3];
   logic [2:0]  p_nsig[3];
   int unsigned mag, lim, tr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wait = 0;
         m_done = 1'b0;
         for (int k = 0; k < 3; k++) begin
            m_dout[k] = '0; m_neg[k] = 1'b0; m_ovf[k] = 1'b0; m_nsig[k] = '0;
         end
      end else if (m_done) begin
         if (out_ready) m_done = 1'b0;
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            m_done = 1'b1;
            for (int k = 0; k < 3; k++) begin
               m_dout[k] = p_dout[k]; m_neg[k] = p_neg[k];
               m_ovf[k]  = p_ovf[k];  m_nsig[k] = p_nsig[k];
            end
         end
      end else if (in_valid) begin
         m_wait = 16;
         for (int k = 0; k < 3; k++) begin
            p_neg[k]  = sg(k) && din[15];
            mag       = p_neg[k] ? (32'd65536 - 32'(din)) : 32'(din);
            lim       = 10 ** dg(k);
            tr        = mag % lim;
            p_ovf[k]  = (mag >= lim);
            p_dout[k] = to_bcd(tr);
            p_nsig[k] = nsig_of(tr);
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk("in_ready",  k, 32'(ir[k]),  32'(m_wait == 0 && !m_done));
         chk("out_valid", k, 32'(ov[k]),  32'(m_done));
         chk("dout",      k, 32'(dd[k]),  32'(m_dout[k]));
         chk("neg",       k, 32'(dng[k]), 32'(m_neg[k]));
         chk("ovf",       k, 32'(dof[k]), 32'(m_ovf[k]));
         chk("nsig",      k, 32'(dns[k]), 32'(m_nsig[k]));
      end
   end

   // ---------------- driver ----------------
   // Starts at a falling edge; ends at the falling edge right after the output handshake.
   task automatic run(input logic [15:0] d, input int hold, input bit poke,
                      input logic [15:0] poke_d, output int lat);
      int n;
      lat = 0;
      din = d;
      in_valid = 1'b1;
      n = 0;
      while (!ir[0] && n < 60) begin @(negedge clk); n++; end
      if (!ir[0]) begin
         failures++; checks++;
         $display("FAIL accept_timeout actual=busy required=idle t=%0t", $time);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      if (poke) din = poke_d;
      else in_valid = 1'b0;
      n = 0;
      while (!ov[0] && n < 60) begin @(posedge clk); lat++; @(negedge clk); n++; end
      if (!ov[0]) begin
         failures++; checks++;
         $display("FAIL done_timeout actual=no_valid required=valid t=%0t", $time);
         return;
      end
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic [15:0] d, pd;
      logic [15:0] corner[8];
      corner[0] = 16'd0;     corner[1] = 16'd9999;  corner[2] = 16'd10000;
      corner[3] = 16'hFFFF;  corner[4] = 16'h8000;  corner[5] = 16'h7FFF;
      corner[6] = 16'd65535; corner[7] = 16'd1;

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 0, 32'(ir[0]), 32'd1);
      chk("rst_dout",     0, 32'(dd[0]), 32'd0);
      chk("rst_nsig",     0, 32'(dns[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run(16'd65535, 0, 1'b0, 16'd0, lat);
      chk("latency",     0, 32'(lat),    32'd17);
      chk("lit_dout",    0, 32'(dd[0]),  32'h65535);
      chk("lit_nsig",    0, 32'(dns[0]), 32'd5);
      chk("lit_ovf",     0, 32'(dof[0]), 32'd0);
      chk("single_cyc",  0, 32'(ov[0]),  32'd0);
      chk("lit_d4_dout", 1, 32'(dd[1]),  32'h5535);
      chk("lit_d4_ovf",  1, 32'(dof[1]), 32'd1);
      chk("lit_s_dout",  2, 32'(dd[2]),  32'h00001);
      chk("lit_s_neg",   2, 32'(dng[2]), 32'd1);
      chk("lit_s_nsig",  2, 32'(dns[2]), 32'd1);

      run(16'd0, 0, 1'b0, 16'd0, lat);
      chk("zero_dout", 0, 32'(dd[0]),  32'd0);
      chk("zero_nsig", 0, 32'(dns[0]), 32'd1);
      run(16'd1000, 0, 1'b0, 16'd0, lat);
      chk("k_dout", 0, 32'(dd[0]),  32'h01000);
      chk("k_nsig", 0, 32'(dns[0]), 32'd4);

      run(16'd12345, 1, 1'b0, 16'd0, lat);
      chk("d4_dout", 1, 32'(dd[1]),  32'h2345);
      chk("d4_ovf",  1, 32'(dof[1]), 32'd1);
      chk("d4_nsig", 1, 32'(dns[1]), 32'd4);
      run(16'd9999, 0, 1'b0, 16'd0, lat);
      chk("d4_9999_ovf", 1, 32'(dof[1]), 32'd0);

      run(16'h8000, 0, 1'b0, 16'd0, lat);
      chk("s_min_neg",  2, 32'(dng[2]), 32'd1);
      chk("s_min_dout", 2, 32'(dd[2]),  32'h32768);
      run(16'h7FFF, 0, 1'b0, 16'd0, lat);
      chk("s_max_neg",  2, 32'(dng[2]), 32'd0);
      chk("s_max_dout", 2, 32'(dd[2]),  32'h32767);

      run(16'd42, 5, 1'b1, 16'd7, lat);
      chk("bp_dout", 0, 32'(dd[0]), 32'h00042);
      run(16'd7, 0, 1'b0, 16'd0, lat);
      chk("after_bp_dout", 0, 32'(dd[0]), 32'h00007);

      // Abort a conversion partway through with an asynchronous reset.
      din = 16'd54321;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_valid", 0, 32'(ov[0]), 32'd0);
      chk("abort_dout",  0, 32'(dd[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("abort_ready", 0, 32'(ir[0]), 32'd1);
      run(16'd5, 0, 1'b0, 16'd0, lat);
      chk("post_rst_dout", 0, 32'(dd[0]), 32'h00005);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) d = corner[$urandom_range(0, 7)];
         else d = 16'($urandom_range(0, 65535));
         pd = 16'($urandom_range(0, 65535));
         run(d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), pd, lat);
         chk("rand_latency", 0, 32'(lat), 32'd17);
      end

      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
